// File: rtl/twiddle_stage_loader_if.sv
// Handshake and per-stage RAM write bus for the twiddle stage loader.
// The master drives the load request and the base twiddle stream; the slave is the loader.
interface twiddle_stage_loader_if #(
    parameter int W          = 32,
    parameter int NUM_stages = 4,
    parameter int ADDR_WIDTH = 3
);
    logic                                  load_start;
    logic [NUM_stages-1:0]                 stage_mask;
    logic                                  tw_valid;
    logic [W-1:0]                          tw_data;
    logic                                  tw_ready;
    logic [NUM_stages-1:0]                 write_en_array;
    logic [NUM_stages-1:0][ADDR_WIDTH-1:0] write_addr_array;
    logic [NUM_stages-1:0][W-1:0]          write_data_array;
    logic                                  busy;
    logic                                  done;

    modport master (
        output load_start, stage_mask, tw_valid, tw_data,
        input  tw_ready, write_en_array, write_addr_array, write_data_array, busy, done
    );

    modport slave (
        input  load_start, stage_mask, tw_valid, tw_data,
        output tw_ready, write_en_array, write_addr_array, write_data_array, busy, done
    );
endinterface

// File: rtl/twiddle_stage_loader.sv
// Captures radix/2 base twiddle words, then writes the decimated subset buf[idx<<s]
// into each selected stage RAM, one write per cycle, lowest selected stage first.
module twiddle_stage_loader #(
    parameter int W          = 32,
    parameter int radix      = 16,
    parameter int NUM_stages = $clog2(radix),
    parameter int ADDR_WIDTH = $clog2(radix/2)
) (
    input logic clk,
    input logic rst,
    twiddle_stage_loader_if.slave bus
);

    localparam int HALF = radix / 2;
    localparam int SW   = (NUM_stages > 1) ? $clog2(NUM_stages) : 1;

    typedef enum logic [1:0] {IDLE, CAPTURE, WRITE, DONE} state_t;

    state_t                state;
    logic [NUM_stages-1:0] mask_q;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] idx;
    logic [SW-1:0]         stage;
    logic [W-1:0]          tw_buf [HALF];

    logic                                  accept;
    logic                                  first_found;
    logic                                  next_found;
    logic [SW-1:0]                         first_s;
    logic [SW-1:0]                         next_s;
    logic [ADDR_WIDTH-1:0]                 last_idx;
    logic                                  nxt_valid;
    logic [SW-1:0]                         nxt_s;
    logic [ADDR_WIDTH-1:0]                 nxt_idx;
    logic [NUM_stages-1:0]                 en_d;
    logic [NUM_stages-1:0][ADDR_WIDTH-1:0] addr_d;
    logic [NUM_stages-1:0][W-1:0]          data_d;

    assign accept = bus.tw_valid && bus.tw_ready;

    // NOTE: the capture buffer has no reset; every sequence overwrites all entries before reading them.
    always_ff @(posedge clk) begin
        if (state == CAPTURE && accept) begin
            tw_buf[cnt] <= bus.tw_data;
        end
    end

    // Next write to present: (stage, idx) after the one currently on the lanes,
    // or the first write of the sequence when leaving CAPTURE.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        first_found = 1'b0;
        first_s     = '0;
        next_found  = 1'b0;
        next_s      = '0;
        for (int i = NUM_stages - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                first_found = 1'b1;
                first_s     = SW'(i);
            end
            if (mask_q[i] && i > int'(stage)) begin
                next_found = 1'b1;
                next_s     = SW'(i);
            end
        end

        last_idx = ADDR_WIDTH'((radix >> (int'(stage) + 1)) - 1);

        if (state == WRITE) begin
            if (idx == last_idx) begin
                nxt_valid = next_found;
                nxt_s     = next_s;
                nxt_idx   = '0;
            end else begin
                nxt_valid = 1'b1;
                nxt_s     = stage;
                nxt_idx   = idx + ADDR_WIDTH'(1);
            end
        end else begin
            nxt_valid = first_found;
            nxt_s     = first_s;
            nxt_idx   = '0;
        end

        en_d   = '0;
        addr_d = '0;
        data_d = '0;
        if (nxt_valid) begin
            en_d[nxt_s]   = 1'b1;
            addr_d[nxt_s] = nxt_idx;
            data_d[nxt_s] = tw_buf[nxt_idx << nxt_s];
        end
    end

    // NOTE: all state and output registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                <= IDLE;
            mask_q               <= '0;
            cnt                  <= '0;
            idx                  <= '0;
            stage                <= '0;
            bus.tw_ready         <= 1'b0;
            bus.busy             <= 1'b0;
            bus.done             <= 1'b0;
            bus.write_en_array   <= '0;
            bus.write_addr_array <= '0;
            bus.write_data_array <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.load_start) begin
                        mask_q       <= bus.stage_mask;
                        cnt          <= '0;
                        bus.tw_ready <= 1'b1;
                        bus.busy     <= 1'b1;
                        state        <= CAPTURE;
                    end
                end

                CAPTURE: begin
                    if (accept) begin
                        cnt <= cnt + ADDR_WIDTH'(1);
                        if (cnt == ADDR_WIDTH'(HALF - 1)) begin
                            // Last word: the first write goes out on this same edge.
                            bus.tw_ready         <= 1'b0;
                            stage                <= nxt_s;
                            idx                  <= nxt_idx;
                            bus.write_en_array   <= en_d;
                            bus.write_addr_array <= addr_d;
                            bus.write_data_array <= data_d;
                            if (nxt_valid) begin
                                state <= WRITE;
                            end else begin
                                bus.done <= 1'b1;
                                state    <= DONE;
                            end
                        end
                    end
                end

                WRITE: begin
                    stage                <= nxt_s;
                    idx                  <= nxt_idx;
                    bus.write_en_array   <= en_d;
                    bus.write_addr_array <= addr_d;
                    bus.write_data_array <= data_d;
                    if (!nxt_valid) begin
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end
                end

                DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    idx      <= '0;
                    state    <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/twiddle_stage_loader.md
TWIDDLE_STAGE_LOADER -- requirements
Module: twiddle_stage_loader

Interface
REQ-001 SHALL have parameter W, default 32: twiddle word width in bits.
REQ-002 SHALL have parameter radix, default 16: transform size, a power of two and at least 4.
REQ-003 SHALL have parameter NUM_stages, default $clog2(radix): number of butterfly stages.
REQ-004 SHALL have parameter ADDR_WIDTH, default $clog2(radix/2): per-stage twiddle RAM address width.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port load_start, input, 1 bit: single-cycle request to begin a load sequence.
REQ-008 SHALL have port stage_mask, input, NUM_stages bits: bit s set means stage s is written; sampled with load_start.
REQ-009 SHALL have port tw_valid, input, 1 bit: base twiddle word valid.
REQ-010 SHALL have port tw_data, input, W bits: base twiddle word.
REQ-011 SHALL have port tw_ready, output, 1 bit: block accepts tw_data.
REQ-012 SHALL have port write_en_array, output, [NUM_stages] bits: per-stage RAM write enable.
REQ-013 SHALL have port write_addr_array, output, [NUM_stages][ADDR_WIDTH] bits: per-stage RAM write address.
REQ-014 SHALL have port write_data_array, output, [NUM_stages][W] bits: per-stage RAM write data.
REQ-015 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-016 SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-017 SHALL implement FSM states IDLE, CAPTURE, WRITE and DONE.
REQ-018 In IDLE, load_start=1 SHALL latch stage_mask into mask_q and go to CAPTURE with capture count 0.
REQ-019 In IDLE, if latched stage_mask is 0, the FSM SHALL still capture all words, then go directly to DONE with no writes.
REQ-020 load_start SHALL be ignored in all states other than IDLE.
REQ-021 In CAPTURE, tw_ready SHALL be 1; each cycle with tw_valid&&tw_ready stores tw_data into buf[cnt] and increments cnt.
REQ-022 tw_ready SHALL be 0 in IDLE, WRITE and DONE; tw_valid stalls (tw_valid=0) SHALL pause capture without losing data.
REQ-023 On the radix/2-th accepted word, the FSM SHALL enter WRITE with s set to the lowest set bit of mask_q and idx=0.
REQ-024 In WRITE, stage s SHALL receive radix/2^(s+1) writes, idx = 0 .. radix/2^(s+1)-1, one write per cycle.
REQ-025 For each write: write_en_array[s]=1, write_addr_array[s]=idx, write_data_array[s]=buf[idx<<s].
REQ-026 After a stage's last index, s SHALL advance to the next set bit of mask_q with no idle cycle; with no further set bit, the FSM SHALL go to DONE.
REQ-027 At most one write_en_array bit SHALL be high in any cycle.
REQ-028 Address and data lanes of non-writing stages SHALL be 0.
REQ-029 All outputs SHALL be registered.
REQ-030 The first write SHALL appear in the cycle after the last capture handshake.
REQ-031 done SHALL be 1 for exactly one cycle, in the DONE state, which is the cycle after the last write; the FSM then returns to IDLE.
REQ-032 Write-phase latency SHALL equal the sum over set mask bits of radix/2^(s+1); for radix=16 with a full mask this is 15 cycles.
REQ-033 buf SHALL hold radix/2 words of W bits; its contents are not cleared by reset.

Reset
REQ-034 While rst=1, and asynchronously on assertion: state=IDLE, cnt=0, idx=0, mask_q=0, and tw_ready, busy, done, write_en_array, write_addr_array and write_data_array all 0.
REQ-035 Reset asserted mid-CAPTURE or mid-WRITE SHALL abort the sequence with no further writes; a new load_start after deassertion restarts from capture word 0.

Verification
Base word sequence for scenarios V1-V5 (W=32, radix=16), in arrival order w0..w7: 15C1, 1B30, 0E0E, 0425, 061E, 10AA, 092F, 14E1.
V1: load_start, mask=4'b1111, words sent back to back -> stage0 gets addr0-7 = w0..w7; stage1 gets 15C1, 0E0E, 061E, 092F; stage2 gets 15C1, 061E; stage3 gets 15C1; 15 write cycles total; done 1 cycle after the last write.
V2: mask=4'b0101 -> only stage0 (8 writes) then stage2 (2 writes: 15C1, 061E); write_en_array[1] and write_en_array[3] never high; done after 10 write cycles.
V3: tw_valid low for 3 cycles after w3 -> capture pauses; stored data identical to V1; first write follows the w7 handshake by 1 cycle.
V4: load_start pulsed again during WRITE -> ignored; single done; write count unchanged.
V5: rst asserted during stage1 writes -> all outputs 0 immediately; after release, load_start with mask=4'b1000 -> capture w0..w7, then exactly one write, addr0=15C1, then done.
V6: mask=0 -> 8 words captured, no write_en, done 1 cycle after the last capture handshake.
